// File: rtl/lcd_channel_formatter.sv
// lcd_channel_formatter: renders NUM_CH channel values as "vK=ddddd" fields into a 32-char LCD image.
// Latency: GO rises 3+NUM_CH*DATA_W cycles (decimal) or 3+NUM_CH (hex) after the edge entering S_LATCH.
// Backpressure: waits in S_INIT/S_GO while LCDBusy=1; LCDAck held until LCDUpdate is released.
// Optional hex formatting is compiled in only when LCD_FMT_HEX_EN is defined.
module lcd_channel_formatter #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 10
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_CH*DATA_W-1:0] DataIn,
    input  logic                     HexMode,
    input  logic                     LCDUpdate,
    input  logic                     LCDBusy,
    output logic                     LCDAck,
    output logic                     GO,
    output logic [256:1]             Display
);

    localparam logic [256:1] SPACES = {32{8'h20}};

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LATCH,
        S_CONV,
        S_FMT,
        S_GO,
        S_ACK
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   go_nxt;

    // Snapshot of all channels; the channel being converted always sits in the low DATA_W bits.
    logic [NUM_CH*DATA_W-1:0] snap;
    logic [NUM_CH*DATA_W-1:0] snap_nxt;
    // Double-dabble working registers: sh feeds bits MSB-first into the 5-digit BCD accumulator.
    logic [DATA_W-1:0]        sh;
    logic [19:0]              bcd;
    logic [19:0]              bcd_adj;
    logic [4:0]               bit_cnt;
    logic [1:0]               ch_cnt;
    logic                     hex_q;
    // Per-channel result: 5 BCD digits, or 4 hex nibbles zero-extended to 20 bits.
    logic [19:0]              res [4];
    logic                     bit_last;
    logic                     ch_last;
    logic                     conv_done;
    logic [256:1]             disp_fmt;
    logic                     unused_bits;

`ifdef LCD_FMT_HEX_EN
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`else
    logic unused_hex_mode;
    assign unused_hex_mode = HexMode;
`endif

    assign snap_nxt  = snap >> DATA_W;
    assign bit_last  = (bit_cnt == 5'(DATA_W - 1));
    assign ch_last   = (ch_cnt == 2'(NUM_CH - 1));
    assign conv_done = hex_q ? ch_last : (ch_last && bit_last);
    assign LCDAck    = (state == S_ACK);
    // The adjusted MSB is always zero because the final result fits in 5 digits.
    assign unused_bits = bcd_adj[19];

    // Add-3 correction of every BCD digit that is 5 or more, ahead of this cycle's shift.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < 5; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // State and GO strobe registers; GO is registered so it is a clean one-cycle pulse.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= S_INIT;
            GO    <= 1'b0;
        end else begin
            state <= state_nxt;
            GO    <= go_nxt;
        end
    end

    // Next-state and GO request; GO is raised while still in S_INIT/S_GO and the state moves on once it is seen.
    always_comb begin
        state_nxt = state;
        go_nxt    = 1'b0;
        case (state)
            S_INIT: begin
                if (GO) begin
                    state_nxt = S_IDLE;
                end else if (!LCDBusy) begin
                    go_nxt = 1'b1;
                end
            end
            S_IDLE: begin
                if (LCDUpdate) begin
                    state_nxt = S_LATCH;
                end
            end
            S_LATCH: state_nxt = S_CONV;
            S_CONV: begin
                if (conv_done) begin
                    state_nxt = S_FMT;
                end
            end
            S_FMT: state_nxt = S_GO;
            S_GO: begin
                if (GO) begin
                    state_nxt = S_ACK;
                end else if (!LCDBusy) begin
                    go_nxt = 1'b1;
                end
            end
            S_ACK: begin
                if (!LCDUpdate) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Snapshot, conversion and Display registers.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            snap    <= '0;
            sh      <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            ch_cnt  <= '0;
            hex_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                res[k] <= '0;
            end
            Display <= SPACES;
        end else begin
            case (state)
                S_INIT: Display <= SPACES;
                S_LATCH: begin
                    snap    <= DataIn;
                    sh      <= DataIn[DATA_W-1:0];
                    bcd     <= '0;
                    bit_cnt <= '0;
                    ch_cnt  <= '0;
`ifdef LCD_FMT_HEX_EN
                    hex_q   <= HexMode;
`else
                    hex_q   <= 1'b0;
`endif
                end
                S_CONV: begin
`ifdef LCD_FMT_HEX_EN
                    if (hex_q) begin
                        res[ch_cnt] <= {4'h0, 16'(snap[DATA_W-1:0])};
                        snap        <= snap_nxt;
                        ch_cnt      <= ch_cnt + 2'd1;
                    end else
`endif
                    begin
                        if (bit_last) begin
                            res[ch_cnt] <= {bcd_adj[18:0], sh[DATA_W-1]};
                            bcd         <= '0;
                            bit_cnt     <= '0;
                            ch_cnt      <= ch_cnt + 2'd1;
                            snap        <= snap_nxt;
                            sh          <= snap_nxt[DATA_W-1:0];
                        end else begin
                            bcd     <= {bcd_adj[18:0], sh[DATA_W-1]};
                            sh      <= sh << 1;
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                S_FMT: Display <= disp_fmt;
                default: ;
            endcase
        end
    end

    // Character image: field k is "v", '0'+k, "=", then five digits; unused fields stay blank.
    always_comb begin
        disp_fmt = SPACES;
        for (int k = 0; k < 4; k++) begin
            if (k < NUM_CH) begin
                disp_fmt[256-64*k -: 8] = 8'h76;
                disp_fmt[248-64*k -: 8] = 8'h30 + 8'(k);
                disp_fmt[240-64*k -: 8] = 8'h3D;
                for (int j = 0; j < 5; j++) begin
                    disp_fmt[232-64*k-8*j -: 8] = 8'h30 + {4'h0, res[k][4*(4-j) +: 4]};
`ifdef LCD_FMT_HEX_EN
                    if (hex_q) begin
                        disp_fmt[232-64*k-8*j -: 8] = (j == 0) ? 8'h20 : hex_char(res[k][4*(4-j) +: 4]);
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_channel_formatter.sv
// tb_lcd_channel_formatter: directed updates on a 2x10 and a 4x16 formatter with a scoreboard queue.
// Latency: checks GO cycle against 3+conversion cycles(+busy stall) after the latch edge.
// Backpressure: drives LCDBusy stalls and LCDUpdate hold/drop around the acknowledge.
module tb_lcd_channel_formatter;

`ifdef LCD_FMT_HEX_EN
    localparam bit HEX_EN = 1'b1;
`else
    localparam bit HEX_EN = 1'b0;
`endif
    localparam logic [256:1] SPACES = {32{8'h20}};

    typedef struct {
        logic [256:1] disp;
        int           cyc;
    } exp_t;

    logic         Clk = 1'b0;
    logic         rst;
    logic [19:0]  data_a;
    logic [63:0]  data_b;
    logic         hex;
    logic         upd_a, upd_b, busy_a, busy_b;
    logic         ack_a, ack_b, go_a, go_b;
    logic [256:1] disp_a, disp_b;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    lcd_channel_formatter #(.NUM_CH(2), .DATA_W(10)) dut (
        .Clk(Clk), .Rst(rst), .DataIn(data_a), .HexMode(hex), .LCDUpdate(upd_a),
        .LCDBusy(busy_a), .LCDAck(ack_a), .GO(go_a), .Display(disp_a)
    );

    lcd_channel_formatter #(.NUM_CH(4), .DATA_W(16)) dut4 (
        .Clk(Clk), .Rst(rst), .DataIn(data_b), .HexMode(hex), .LCDUpdate(upd_b),
        .LCDBusy(busy_b), .LCDAck(ack_b), .GO(go_b), .Display(disp_b)
    );

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [256:1] obs, input logic [256:1] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected 32-character image built from the values with integer arithmetic.
    function automatic logic [256:1] build(input int nch, input bit hx,
                                           input logic [15:0] v0, input logic [15:0] v1,
                                           input logic [15:0] v2, input logic [15:0] v3);
        logic [256:1] d;
        logic [15:0]  v;
        logic [7:0]   c;
        string        hexd;
        int           pos;
        int           p;
        hexd = "0123456789ABCDEF";
        d = SPACES;
        for (int k = 0; k < nch; k++) begin
            v = (k == 0) ? v0 : (k == 1) ? v1 : (k == 2) ? v2 : v3;
            for (int j = 0; j < 8; j++) begin
                pos = 8 * k + j + 1;
                if (j == 0) c = 8'h76;
                else if (j == 1) c = 8'(48 + k);
                else if (j == 2) c = 8'h3D;
                else if (hx) begin
                    if (j == 3) c = 8'h20;
                    else c = hexd.getc(int'((v >> (4 * (7 - j))) & 16'hF));
                end else begin
                    p = 1;
                    for (int i = 0; i < 7 - j; i++) p = p * 10;
                    c = 8'(48 + (int'(v) / p) % 10);
                end
                d[264-8*pos -: 8] = c;
            end
        end
        return d;
    endfunction

    // One update: push expectation, request, wait for GO (bounded), then check GO width and ack handshake.
    task automatic run(input bit s, input logic [63:0] din, input bit hx, input int busy_n,
                       input bit drop, input bit chg);
        exp_t        e;
        int          k, nch, dw, n;
        bit          eh;
        logic [15:0] v[4];
        nch = s ? 4 : 2;
        dw  = s ? 16 : 10;
        for (int c = 0; c < 4; c++)
            v[c] = (c < nch) ? 16'((din >> (c * dw)) & ((64'd1 << dw) - 64'd1)) : 16'd0;
        eh = hx && HEX_EN;
        n  = eh ? nch : nch * dw;
        e.disp = build(nch, eh, v[0], v[1], v[2], v[3]);
        e.cyc  = 3 + n + busy_n;
        sb.push_back(e);

        @(negedge Clk);
        hex = hx;
        if (s) begin data_b = din; busy_b = (busy_n > 0); upd_b = 1'b1; end
        else begin data_a = din[19:0]; busy_a = (busy_n > 0); upd_a = 1'b1; end
        @(posedge Clk);
        k = 0;
        while (!(s ? go_b : go_a) && k < 400) begin
            @(posedge Clk); #1;
            k++;
            if (k == 2 && drop) begin upd_a = 1'b0; upd_b = 1'b0; end
            if (k == 2 && chg) begin data_a = ~din[19:0]; data_b = ~din; end
            if (busy_n > 0 && k == n + 2) chk_w("display_before_go", s ? disp_b : disp_a, e.disp);
            if (busy_n > 0 && k == n + 2 + busy_n) begin busy_a = 1'b0; busy_b = 1'b0; end
        end
        e = sb.pop_front();
        chk_i("go_cycle", k, e.cyc);
        chk_w("display", s ? disp_b : disp_a, e.disp);
        @(posedge Clk); #1;
        chk_b("go_width", s ? go_b : go_a, 1'b0);
        chk_b("ack_on", s ? ack_b : ack_a, 1'b1);
        chk_w("display_hold", s ? disp_b : disp_a, e.disp);
        if (drop) begin
            @(posedge Clk); #1;
            chk_b("ack_drop_exit", s ? ack_b : ack_a, 1'b0);
        end else begin
            repeat (3) begin
                @(posedge Clk); #1;
                chk_b("ack_hold", s ? ack_b : ack_a, 1'b1);
                chk_b("no_retrigger", s ? go_b : go_a, 1'b0);
            end
            @(negedge Clk);
            upd_a = 1'b0; upd_b = 1'b0;
            @(posedge Clk); #1;
            chk_b("ack_release", s ? ack_b : ack_a, 1'b0);
        end
        busy_a = 1'b0; busy_b = 1'b0;
        @(posedge Clk); #1;
    endtask

    initial begin
        int cnt_a, cnt_b, first_a, first_b;
        rst = 1'b0; data_a = '0; data_b = '0; hex = 1'b0;
        upd_a = 1'b0; upd_b = 1'b0; busy_a = 1'b0; busy_b = 1'b0;

        // Reset state.
        repeat (3) @(posedge Clk);
        #1;
        chk_b("rst_go", go_a, 1'b0);
        chk_b("rst_ack", ack_a, 1'b0);
        chk_w("rst_display", disp_a, SPACES);
        chk_b("rst_go4", go_b, 1'b0);
        chk_w("rst_display4", disp_b, SPACES);

        // Exactly one blanking GO after release, on the first edge.
        @(negedge Clk);
        rst = 1'b1;
        cnt_a = 0; cnt_b = 0; first_a = 0; first_b = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge Clk); #1;
            if (go_a) begin cnt_a++; if (first_a == 0) first_a = i; end
            if (go_b) begin cnt_b++; if (first_b == 0) first_b = i; end
        end
        chk_i("blank_go_count", cnt_a, 1);
        chk_i("blank_go_edge", first_a, 1);
        chk_i("blank_go_count4", cnt_b, 1);
        chk_w("blank_display", disp_a, SPACES);

        // Decimal {1023,37}; hex of the same data; 4x16 all-ones; busy stall; latched data with drop.
        run(1'b0, 64'({10'd1023, 10'd37}), 1'b0, 0, 1'b0, 1'b0);
        run(1'b0, 64'({10'd1023, 10'd37}), 1'b1, 0, 1'b0, 1'b0);
        run(1'b1, {4{16'hFFFF}}, 1'b0, 0, 1'b0, 1'b0);
        run(1'b0, 64'({10'd512, 10'd0}), 1'b0, 10, 1'b0, 1'b0);
        run(1'b0, 64'({10'd640, 10'd9}), 1'b1, 0, 1'b1, 1'b1);

        // Reset in the middle of a conversion.
        @(negedge Clk);
        data_a = {10'd300, 10'd200}; hex = 1'b0; upd_a = 1'b1;
        @(posedge Clk);
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        rst = 1'b0; upd_a = 1'b0;
        @(posedge Clk); #1;
        chk_b("midconv_rst_go", go_a, 1'b0);
        chk_b("midconv_rst_ack", ack_a, 1'b0);
        chk_w("midconv_rst_display", disp_a, SPACES);
        @(negedge Clk);
        rst = 1'b1;
        cnt_a = 0; first_a = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge Clk); #1;
            if (go_a) begin cnt_a++; if (first_a == 0) first_a = i; end
        end
        chk_i("reblank_go_count", cnt_a, 1);
        chk_i("reblank_go_edge", first_a, 1);

        // Normal operation after the reset.
        run(1'b0, 64'({10'd0, 10'd1}), 1'b0, 0, 1'b0, 1'b0);
        chk_i("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
